timer_irq: RTL and testbench

TIMER_IRQ -- requirements
Module: timer_irq

---
 rtl/timer_irq.sv | 149 ++++++++++++++
 tb/tb_timer_irq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - 16-bit prescaled down-counter timer with bus registers and level IRQ
module timer_irq #(
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic [7:0]  DI,
  input  logic        WE,
  output logic [7:0]  DO,
  output logic        OE,
  output logic        IRQ
);

  localparam logic [2:0] OFF_CNTL  = 3'd0;
  localparam logic [2:0] OFF_CNTH  = 3'd1;
  localparam logic [2:0] OFF_LATL  = 3'd2;
  localparam logic [2:0] OFF_LATH  = 3'd3;
  localparam logic [2:0] OFF_CTRL  = 3'd4;
  localparam logic [2:0] OFF_STAT  = 3'd5;
  localparam logic [2:0] OFF_PRESC = 3'd6;

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] lat_q, lat_d;
  logic [7:0]  snap_q, snap_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  presc_q, presc_d;
  logic        en_q, en_d;
  logic        cont_q, cont_d;
  logic        ie_q, ie_d;
  logic        if_q, if_d;
  logic [7:0]  do_q, do_d;
  logic        oe_q, oe_d;

  logic       sel;
  logic       wr;
  logic       rd;
  logic [2:0] off;
  logic       tick;

  assign sel  = (AB[15:3] == BASE[15:3]);
  assign off  = AB[2:0];
  assign wr   = sel & WE;
  assign rd   = sel & ~WE;
  assign tick = en_q & (pcnt_q == 8'd0);

  always_comb begin
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    snap_d  = snap_q;
    pcnt_d  = pcnt_q;
    presc_d = presc_q;
    en_d    = en_q;
    cont_d  = cont_q;
    ie_d    = ie_q;
    if_d    = if_q;
    do_d    = 8'h00;
    oe_d    = rd;

    // W1C is applied before the tick so a simultaneous underflow set wins
    if (wr && (off == OFF_STAT) && DI[0]) begin
      if_d = 1'b0;
    end

    if (en_q) begin
      pcnt_d = tick ? presc_q : (pcnt_q - 8'd1);
    end

    if (tick) begin
      if (cnt_q != 16'h0000) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        if_d = 1'b1;
        if (cont_q) begin
          cnt_d = lat_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    // Register writes come last so they override a same-cycle tick
    if (wr) begin
      case (off)
        OFF_LATL:  lat_d[7:0] = DI;
        OFF_LATH: begin
          lat_d[15:8] = DI;
          cnt_d       = {DI, lat_q[7:0]};
          pcnt_d      = 8'd0;
          en_d        = 1'b1;
        end
        OFF_CTRL: begin
          en_d   = DI[0];
          cont_d = DI[1];
          ie_d   = DI[2];
        end
        OFF_PRESC: presc_d = DI;
        default: ;
      endcase
    end

    if (rd) begin
      case (off)
        OFF_CNTL: begin
          do_d   = cnt_q[7:0];
          snap_d = cnt_q[15:8];
        end
        OFF_CNTH:  do_d = snap_q;
        OFF_CTRL:  do_d = {5'b0, ie_q, cont_q, en_q};
        OFF_STAT:  do_d = {7'b0, if_q};
        OFF_PRESC: do_d = presc_q;
        default:   do_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cnt_q   <= 16'h0000;
      lat_q   <= 16'hFFFF;
      snap_q  <= 8'h00;
      pcnt_q  <= 8'h00;
      presc_q <= 8'h00;
      en_q    <= 1'b0;
      cont_q  <= 1'b0;
      ie_q    <= 1'b0;
      if_q    <= 1'b0;
      do_q    <= 8'h00;
      oe_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      snap_q  <= snap_d;
      pcnt_q  <= pcnt_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      cont_q  <= cont_d;
      ie_q    <= ie_d;
      if_q    <= if_d;
      do_q    <= do_d;
      oe_q    <= oe_d;
    end
  end

  assign DO  = do_q;
  assign OE  = oe_q;
  assign IRQ = if_q & ie_q;

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - directed self-checking bench for timer_irq
module tb_timer_irq;

  localparam logic [15:0] BASE    = 16'hFE00;
  localparam logic [15:0] A_CNTL  = BASE + 16'd0;
  localparam logic [15:0] A_CNTH  = BASE + 16'd1;
  localparam logic [15:0] A_LATL  = BASE + 16'd2;
  localparam logic [15:0] A_LATH  = BASE + 16'd3;
  localparam logic [15:0] A_CTRL  = BASE + 16'd4;
  localparam logic [15:0] A_STAT  = BASE + 16'd5;
  localparam logic [15:0] A_PRESC = BASE + 16'd6;
  localparam logic [15:0] A_RSVD  = BASE + 16'd7;
  localparam logic [15:0] A_IDLE  = 16'h0000;

  logic        clk;
  logic        RST;
  logic [15:0] AB;
  logic [7:0]  DI;
  logic        WE;
  logic [7:0]  DO;
  logic        OE;
  logic        IRQ;

  int n_tests;
  int n_fail;

  timer_irq #(.BASE(BASE)) dut (
    .clk(clk),
    .RST(RST),
    .AB(AB),
    .DI(DI),
    .WE(WE),
    .DO(DO),
    .OE(OE),
    .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Tasks start and end just after a falling edge.
  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    AB = a;
    DI = d;
    WE = 1'b1;
    @(negedge clk);
    AB = A_IDLE;
    DI = 8'h00;
    WE = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d, output logic o);
    AB = a;
    WE = 1'b0;
    @(negedge clk);
    d  = DO;
    o  = OE;
    AB = A_IDLE;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       o;
    bus_rd(a, d, o);
    check(tag, {8'h00, d}, {8'h00, exp});
    check({tag, "_oe"}, {15'h0, o}, 16'h0001);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [7:0] rdata;
  logic       roe;
  logic       irq_seen;
  logic [7:0] seq_exp [7];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    AB  = A_IDLE;
    DI  = 8'h00;
    WE  = 1'b0;
    RST = 1'b1;
    #1 RST = 1'b0;
    idle(2);
    check("rst_do", {8'h00, DO}, 16'h0000);
    check("rst_oe", {15'h0, OE}, 16'h0000);
    check("rst_irq", {15'h0, IRQ}, 16'h0000);
    RST = 1'b1;
    rd_chk("rst_ctrl", A_CTRL, 8'h00);
    rd_chk("rst_stat", A_STAT, 8'h00);
    rd_chk("rst_presc", A_PRESC, 8'h00);
    rd_chk("rst_cntl", A_CNTL, 8'h00);
    rd_chk("rst_cnth", A_CNTH, 8'h00);

    // Address decode boundaries
    bus_rd(BASE + 16'd8, rdata, roe);
    check("dec_hi_oe", {15'h0, roe}, 16'h0000);
    check("dec_hi_do", {8'h00, rdata}, 16'h0000);
    bus_rd(BASE - 16'd1, rdata, roe);
    check("dec_lo_oe", {15'h0, roe}, 16'h0000);
    bus_wr(BASE + 16'd14, 8'h55);
    bus_wr(BASE - 16'd2, 8'h55);
    bus_wr(BASE + 16'd12, 8'h07);
    rd_chk("dec_presc", A_PRESC, 8'h00);
    rd_chk("dec_ctrl", A_CTRL, 8'h00);
    rd_chk("rsvd_rd", A_RSVD, 8'h00);
    bus_wr(A_PRESC, 8'hAA);
    rd_chk("presc_rw", A_PRESC, 8'hAA);

    // One-shot: IRQ exactly 4 clocks after the LATH edge
    bus_wr(A_PRESC, 8'h00);
    bus_wr(A_CTRL, 8'h04);
    bus_wr(A_LATL, 8'h03);
    bus_wr(A_LATH, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("os_irq_%0d", i), {15'h0, IRQ}, (i == 4) ? 16'h0001 : 16'h0000);
    end
    rd_chk("os_ctrl", A_CTRL, 8'h04);
    rd_chk("os_stat", A_STAT, 8'h01);
    rd_chk("os_cntl", A_CNTL, 8'h00);
    bus_wr(A_STAT, 8'h01);
    check("os_clr_irq", {15'h0, IRQ}, 16'h0000);

    // W1C in the same cycle as underflow: set wins
    bus_wr(A_CTRL, 8'h04);
    bus_wr(A_LATL, 8'h02);
    bus_wr(A_LATH, 8'h00);
    idle(2);
    bus_wr(A_STAT, 8'h01);
    check("w1c_irq", {15'h0, IRQ}, 16'h0001);
    rd_chk("w1c_stat", A_STAT, 8'h01);
    bus_wr(A_STAT, 8'h01);

    // CTRL write in the same cycle as a one-shot underflow: written EN wins
    bus_wr(A_CTRL, 8'h04);
    bus_wr(A_LATL, 8'h02);
    bus_wr(A_LATH, 8'h00);
    idle(2);
    bus_wr(A_CTRL, 8'h05);
    rd_chk("ctl_col_ctrl", A_CTRL, 8'h05);
    rd_chk("ctl_col_stat", A_STAT, 8'h01);
    bus_wr(A_CTRL, 8'h00);
    bus_wr(A_STAT, 8'h01);

    // Coherent 16-bit read across a tick, then LATH write colliding with a tick
    bus_wr(A_LATL, 8'h00);
    bus_wr(A_LATH, 8'h01);
    rd_chk("coh_lo", A_CNTL, 8'h00);
    idle(1);
    rd_chk("coh_hi", A_CNTH, 8'h01);
    bus_wr(A_LATL, 8'h05);
    bus_wr(A_LATH, 8'h00);
    rd_chk("lath_col", A_CNTL, 8'h05);
    bus_wr(A_CTRL, 8'h00);

    // Continuous mode, PRESC=1, latch=2: IF every 6 clocks
    bus_wr(A_PRESC, 8'h01);
    bus_wr(A_CTRL, 8'h06);
    bus_wr(A_LATL, 8'h02);
    bus_wr(A_LATH, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("cont_irq_%0d", i), {15'h0, IRQ}, (i == 5) ? 16'h0001 : 16'h0000);
    end
    bus_wr(A_STAT, 8'h01);
    for (int i = 7; i <= 11; i++) begin
      @(negedge clk);
      check($sformatf("cont_irq_%0d", i), {15'h0, IRQ}, (i == 11) ? 16'h0001 : 16'h0000);
    end
    seq_exp = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd2};
    for (int i = 0; i < 7; i++) begin
      rd_chk($sformatf("cont_seq_%0d", i), A_CNTL, seq_exp[i]);
    end

    // Asynchronous reset in the middle of a continuous count
    rd_chk("pre_rst_ctrl", A_CTRL, 8'h07);
    check("pre_rst_irq", {15'h0, IRQ}, 16'h0001);
    #2 RST = 1'b0;
    #1;
    check("async_do", {8'h00, DO}, 16'h0000);
    check("async_oe", {15'h0, OE}, 16'h0000);
    check("async_irq", {15'h0, IRQ}, 16'h0000);
    @(negedge clk);
    RST = 1'b1;
    irq_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      irq_seen = irq_seen | IRQ;
    end
    check("post_rst_irq", {15'h0, irq_seen}, 16'h0000);
    rd_chk("post_rst_ctrl", A_CTRL, 8'h00);
    rd_chk("post_rst_cntl", A_CNTL, 8'h00);
    rd_chk("post_rst_stat", A_STAT, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
